// File: rtl/tl_pkg.sv
// Shared TileLink UL/UH definitions for the 2:1 arbiter: opcodes, A-channel payload bundle, beat counting.
package tl_pkg;

    localparam int TL_RS_DEF = 4;
    localparam int TL_AW_DEF = 2;

    localparam logic [2:0] TL_PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] TL_ARITHMETIC_DATA  = 3'd2;
    localparam logic [2:0] TL_LOGICAL_DATA     = 3'd3;
    localparam logic [2:0] TL_GET              = 3'd4;
    localparam logic [2:0] TL_ACCESS_ACK       = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA  = 3'd1;

    // Width-independent A fields; source and address are muxed separately so they follow the module parameters.
    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [3:0]  size;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        corrupt;
    } tl_a_t;

    function automatic logic [10:0] tl_beats(input logic [2:0] opcode, input logic [3:0] size);
        logic w_has_data;
        w_has_data = (opcode == TL_PUT_FULL_DATA) || (opcode == TL_PUT_PARTIAL_DATA) ||
                     (opcode == TL_ARITHMETIC_DATA) || (opcode == TL_LOGICAL_DATA);
        if (w_has_data && (size > 4'd2) && (size <= 4'd12))
            return 11'd1 << (size - 4'd2);
        else
            return 11'd1;
    endfunction

endpackage

// File: rtl/tl_rr_arb2.sv
// Round-robin grant for two A-channel masters with message locking and stall hold.
//  state                      | meaning
//  !locked                    | free: grant follows valids, prio breaks ties
//  locked, beats_left == 0    | stalled first beat held on owner
//  locked, beats_left != 0    | mid-message, owner keeps the channel
module tl_rr_arb2
    import tl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid0,
    input  logic        i_valid1,
    input  logic        i_fire,
    input  logic        i_stall,
    input  logic [10:0] i_beats,
    output logic        o_grant
);

    logic       r_owner;
    logic       r_locked;
    logic       r_prio;
    logic [9:0] r_beats_left;
    logic       w_first_beat;

    always_comb begin
        o_grant = r_owner;
        if (r_locked)
            o_grant = r_owner;
        else if (i_valid0 && i_valid1)
            o_grant = r_prio;
        else if (i_valid0)
            o_grant = 1'b0;
        else if (i_valid1)
            o_grant = 1'b1;
    end

    // A stall-held first beat is locked with no beats counted yet, so it still counts as a first beat.
    assign w_first_beat = !r_locked || (r_beats_left == 10'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owner      <= 1'b0;
            r_locked     <= 1'b0;
            r_prio       <= 1'b0;
            r_beats_left <= 10'd0;
        end else if (i_fire) begin
            if (w_first_beat) begin
                if (i_beats != 11'd1) begin
                    r_locked     <= 1'b1;
                    r_owner      <= o_grant;
                    r_beats_left <= 10'(i_beats - 11'd1);
                end else begin
                    r_locked <= 1'b0;
                    r_prio   <= ~o_grant;
                end
            end else begin
                r_beats_left <= r_beats_left - 10'd1;
                if (r_beats_left == 10'd1) begin
                    r_locked <= 1'b0;
                    r_prio   <= ~o_grant;
                end
            end
        end else if (i_stall) begin
            r_owner  <= o_grant;
            r_locked <= 1'b1;
        end
    end

endmodule

// File: rtl/tl_arbiter_2to1.sv
// 2-master to 1-slave TileLink arbiter: A channel muxed by a round-robin grant, D channel routed by source MSB.
module tl_arbiter_2to1
    import tl_pkg::*;
#(
    parameter int TL_RS = TL_RS_DEF,
    parameter int TL_AW = TL_AW_DEF
) (
    input  logic             arb_clock_i,
    input  logic             arb_reset_i,

    input  logic [2:0]       m0_a_opcode,
    input  logic [2:0]       m0_a_param,
    input  logic [3:0]       m0_a_size,
    input  logic [TL_RS-1:0] m0_a_source,
    input  logic [TL_AW-1:0] m0_a_address,
    input  logic [3:0]       m0_a_mask,
    input  logic [31:0]      m0_a_data,
    input  logic             m0_a_corrupt,
    input  logic             m0_a_valid,
    output logic             m0_a_ready,
    output logic [2:0]       m0_d_opcode,
    output logic [1:0]       m0_d_param,
    output logic [3:0]       m0_d_size,
    output logic [TL_RS-1:0] m0_d_source,
    output logic             m0_d_denied,
    output logic             m0_d_corrupt,
    output logic [31:0]      m0_d_data,
    output logic             m0_d_valid,
    input  logic             m0_d_ready,

    input  logic [2:0]       m1_a_opcode,
    input  logic [2:0]       m1_a_param,
    input  logic [3:0]       m1_a_size,
    input  logic [TL_RS-1:0] m1_a_source,
    input  logic [TL_AW-1:0] m1_a_address,
    input  logic [3:0]       m1_a_mask,
    input  logic [31:0]      m1_a_data,
    input  logic             m1_a_corrupt,
    input  logic             m1_a_valid,
    output logic             m1_a_ready,
    output logic [2:0]       m1_d_opcode,
    output logic [1:0]       m1_d_param,
    output logic [3:0]       m1_d_size,
    output logic [TL_RS-1:0] m1_d_source,
    output logic             m1_d_denied,
    output logic             m1_d_corrupt,
    output logic [31:0]      m1_d_data,
    output logic             m1_d_valid,
    input  logic             m1_d_ready,

    output logic [2:0]       s_a_opcode,
    output logic [2:0]       s_a_param,
    output logic [3:0]       s_a_size,
    output logic [TL_RS:0]   s_a_source,
    output logic [TL_AW-1:0] s_a_address,
    output logic [3:0]       s_a_mask,
    output logic [31:0]      s_a_data,
    output logic             s_a_corrupt,
    output logic             s_a_valid,
    input  logic             s_a_ready,

    input  logic [2:0]       s_d_opcode,
    input  logic [1:0]       s_d_param,
    input  logic [3:0]       s_d_size,
    input  logic [TL_RS:0]   s_d_source,
    input  logic             s_d_denied,
    input  logic             s_d_corrupt,
    input  logic [31:0]      s_d_data,
    input  logic             s_d_valid,
    output logic             s_d_ready
);

    tl_a_t      w_a0;
    tl_a_t      w_a1;
    tl_a_t      w_a_sel;
    logic       w_grant;
    logic       w_valid_sel;
    logic       w_fire;
    logic       w_stall;
    logic       w_d_idx;

    assign w_a0 = '{m0_a_opcode, m0_a_param, m0_a_size, m0_a_mask, m0_a_data, m0_a_corrupt};
    assign w_a1 = '{m1_a_opcode, m1_a_param, m1_a_size, m1_a_mask, m1_a_data, m1_a_corrupt};

    assign w_a_sel     = w_grant ? w_a1 : w_a0;
    assign w_valid_sel = w_grant ? m1_a_valid : m0_a_valid;

    assign s_a_opcode  = w_a_sel.opcode;
    assign s_a_param   = w_a_sel.param;
    assign s_a_size    = w_a_sel.size;
    assign s_a_mask    = w_a_sel.mask;
    assign s_a_data    = w_a_sel.data;
    assign s_a_corrupt = w_a_sel.corrupt;
    assign s_a_source  = {w_grant, (w_grant ? m1_a_source : m0_a_source)};
    assign s_a_address = w_grant ? m1_a_address : m0_a_address;
    assign s_a_valid   = w_valid_sel && !arb_reset_i;

    assign m0_a_ready = !arb_reset_i && !w_grant && s_a_ready;
    assign m1_a_ready = !arb_reset_i &&  w_grant && s_a_ready;

    assign w_fire  = s_a_valid && s_a_ready;
    assign w_stall = s_a_valid && !s_a_ready;

    tl_rr_arb2 u_rr_arb2 (
        .i_clk    (arb_clock_i),
        .i_rst    (arb_reset_i),
        .i_valid0 (m0_a_valid),
        .i_valid1 (m1_a_valid),
        .i_fire   (w_fire),
        .i_stall  (w_stall),
        .i_beats  (tl_beats(w_a_sel.opcode, w_a_sel.size)),
        .o_grant  (w_grant)
    );

    // D path is independent of A: routed purely by the master-index bit in the returned source.
    assign w_d_idx    = s_d_source[TL_RS];
    assign m0_d_valid = s_d_valid && !w_d_idx && !arb_reset_i;
    assign m1_d_valid = s_d_valid &&  w_d_idx && !arb_reset_i;
    assign s_d_ready  = !arb_reset_i && (w_d_idx ? m1_d_ready : m0_d_ready);

    assign m0_d_opcode  = s_d_opcode;
    assign m0_d_param   = s_d_param;
    assign m0_d_size    = s_d_size;
    assign m0_d_source  = s_d_source[TL_RS-1:0];
    assign m0_d_denied  = s_d_denied;
    assign m0_d_corrupt = s_d_corrupt;
    assign m0_d_data    = s_d_data;
    assign m1_d_opcode  = s_d_opcode;
    assign m1_d_param   = s_d_param;
    assign m1_d_size    = s_d_size;
    assign m1_d_source  = s_d_source[TL_RS-1:0];
    assign m1_d_denied  = s_d_denied;
    assign m1_d_corrupt = s_d_corrupt;
    assign m1_d_data    = s_d_data;

endmodule

// File: tb/tb_tl_arbiter_2to1.sv
// Directed, table-driven bench for tl_arbiter_2to1: one table row per clock cycle, plus a 4 KiB burst sequence.
module tb_tl_arbiter_2to1;

    localparam logic [2:0] GET = 3'd4;
    localparam logic [2:0] PF  = 3'd0;
    localparam logic [2:0] LG  = 3'd3;
    localparam logic [31:0] M0_DATA = 32'hA0A0_0000;
    localparam logic [31:0] M1_DATA = 32'hB1B1_0001;
    localparam logic [31:0] SD_DATA = 32'hD00D_F00D;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  m0_a_opcode, m0_a_param, m1_a_opcode, m1_a_param;
    logic [3:0]  m0_a_size, m0_a_source, m0_a_mask, m1_a_size, m1_a_source, m1_a_mask;
    logic [1:0]  m0_a_address, m1_a_address;
    logic [31:0] m0_a_data, m1_a_data;
    logic        m0_a_corrupt, m0_a_valid, m0_a_ready, m1_a_corrupt, m1_a_valid, m1_a_ready;
    logic [2:0]  m0_d_opcode, m1_d_opcode;
    logic [1:0]  m0_d_param, m1_d_param;
    logic [3:0]  m0_d_size, m0_d_source, m1_d_size, m1_d_source;
    logic        m0_d_denied, m0_d_corrupt, m0_d_valid, m0_d_ready;
    logic        m1_d_denied, m1_d_corrupt, m1_d_valid, m1_d_ready;
    logic [31:0] m0_d_data, m1_d_data;
    logic [2:0]  s_a_opcode, s_a_param;
    logic [3:0]  s_a_size, s_a_mask;
    logic [4:0]  s_a_source;
    logic [1:0]  s_a_address;
    logic [31:0] s_a_data;
    logic        s_a_corrupt, s_a_valid, s_a_ready;
    logic [2:0]  s_d_opcode;
    logic [1:0]  s_d_param;
    logic [3:0]  s_d_size;
    logic [4:0]  s_d_source;
    logic        s_d_denied, s_d_corrupt, s_d_valid, s_d_ready;
    logic [31:0] s_d_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tl_arbiter_2to1 #(.TL_RS(4), .TL_AW(2)) dut (
        .arb_clock_i(clk), .arb_reset_i(rst),
        .m0_a_opcode(m0_a_opcode), .m0_a_param(m0_a_param), .m0_a_size(m0_a_size),
        .m0_a_source(m0_a_source), .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask),
        .m0_a_data(m0_a_data), .m0_a_corrupt(m0_a_corrupt), .m0_a_valid(m0_a_valid),
        .m0_a_ready(m0_a_ready),
        .m0_d_opcode(m0_d_opcode), .m0_d_param(m0_d_param), .m0_d_size(m0_d_size),
        .m0_d_source(m0_d_source), .m0_d_denied(m0_d_denied), .m0_d_corrupt(m0_d_corrupt),
        .m0_d_data(m0_d_data), .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready),
        .m1_a_opcode(m1_a_opcode), .m1_a_param(m1_a_param), .m1_a_size(m1_a_size),
        .m1_a_source(m1_a_source), .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask),
        .m1_a_data(m1_a_data), .m1_a_corrupt(m1_a_corrupt), .m1_a_valid(m1_a_valid),
        .m1_a_ready(m1_a_ready),
        .m1_d_opcode(m1_d_opcode), .m1_d_param(m1_d_param), .m1_d_size(m1_d_size),
        .m1_d_source(m1_d_source), .m1_d_denied(m1_d_denied), .m1_d_corrupt(m1_d_corrupt),
        .m1_d_data(m1_d_data), .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready),
        .s_a_opcode(s_a_opcode), .s_a_param(s_a_param), .s_a_size(s_a_size),
        .s_a_source(s_a_source), .s_a_address(s_a_address), .s_a_mask(s_a_mask),
        .s_a_data(s_a_data), .s_a_corrupt(s_a_corrupt), .s_a_valid(s_a_valid),
        .s_a_ready(s_a_ready),
        .s_d_opcode(s_d_opcode), .s_d_param(s_d_param), .s_d_size(s_d_size),
        .s_d_source(s_d_source), .s_d_denied(s_d_denied), .s_d_corrupt(s_d_corrupt),
        .s_d_data(s_d_data), .s_d_valid(s_d_valid), .s_d_ready(s_d_ready)
    );

    typedef struct {
        logic       rst;
        logic       v0;  logic [2:0] op0; logic [3:0] sz0; logic [3:0] src0;
        logic       v1;  logic [2:0] op1; logic [3:0] sz1; logic [3:0] src1;
        logic       sar; logic sdv; logic [4:0] sds; logic d0r; logic d1r;
        logic       e_sav; logic [4:0] e_sas; logic e_r0; logic e_r1;
        logic       e_d0v; logic e_d1v; logic e_sdr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic r, input logic v0, input logic [2:0] op0, input logic [3:0] sz0, input logic [3:0] src0,
        input logic v1, input logic [2:0] op1, input logic [3:0] sz1, input logic [3:0] src1,
        input logic sar, input logic sdv, input logic [4:0] sds, input logic d0r, input logic d1r,
        input logic e_sav, input logic [4:0] e_sas, input logic e_r0, input logic e_r1,
        input logic e_d0v, input logic e_d1v, input logic e_sdr);
        vec_t v;
        v = '{r, v0, op0, sz0, src0, v1, op1, sz1, src1, sar, sdv, sds, d0r, d1r,
              e_sav, e_sas, e_r0, e_r1, e_d0v, e_d1v, e_sdr};
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst;
        m0_a_valid = v.v0; m0_a_opcode = v.op0; m0_a_size = v.sz0; m0_a_source = v.src0;
        m1_a_valid = v.v1; m1_a_opcode = v.op1; m1_a_size = v.sz1; m1_a_source = v.src1;
        s_a_ready = v.sar; s_d_valid = v.sdv; s_d_source = v.sds;
        m0_d_ready = v.d0r; m1_d_ready = v.d1r;
    endtask

    task automatic check_row(input vec_t v, input int row);
        logic g;
        g = v.e_sas[4];
        chk("s_a_valid", row, 64'(s_a_valid), 64'(v.e_sav));
        chk("m0_a_ready", row, 64'(m0_a_ready), 64'(v.e_r0));
        chk("m1_a_ready", row, 64'(m1_a_ready), 64'(v.e_r1));
        chk("m0_d_valid", row, 64'(m0_d_valid), 64'(v.e_d0v));
        chk("m1_d_valid", row, 64'(m1_d_valid), 64'(v.e_d1v));
        chk("s_d_ready", row, 64'(s_d_ready), 64'(v.e_sdr));
        if (v.e_sav) begin
            chk("s_a_source", row, 64'(s_a_source), 64'(v.e_sas));
            chk("s_a_data_addr_op", row, {s_a_data, s_a_address, s_a_opcode},
                {(g ? M1_DATA : M0_DATA), (g ? 2'd2 : 2'd1), (g ? v.op1 : v.op0)});
            chk("s_a_misc", row, 64'({s_a_param, s_a_size, s_a_mask, s_a_corrupt}),
                64'({(g ? 3'd5 : 3'd2), (g ? v.sz1 : v.sz0), (g ? 4'h3 : 4'hF), g}));
        end
        if (v.e_d0v)
            chk("m0_d_fields", row, {m0_d_data, m0_d_source, m0_d_opcode, m0_d_param, m0_d_size, m0_d_denied, m0_d_corrupt},
                {SD_DATA, v.sds[3:0], 3'd1, 2'd0, 4'd2, 1'b1, 1'b0});
        if (v.e_d1v)
            chk("m1_d_fields", row, {m1_d_data, m1_d_source, m1_d_opcode, m1_d_param, m1_d_size, m1_d_denied, m1_d_corrupt},
                {SD_DATA, v.sds[3:0], 3'd1, 2'd0, 4'd2, 1'b1, 1'b0});
    endtask

    initial begin
        rst = 1'b1;
        m0_a_opcode = GET; m0_a_param = 3'd2; m0_a_size = 4'd2; m0_a_source = 4'd0; m0_a_address = 2'd1;
        m0_a_mask = 4'hF; m0_a_data = M0_DATA; m0_a_corrupt = 1'b0; m0_a_valid = 1'b0; m0_d_ready = 1'b0;
        m1_a_opcode = GET; m1_a_param = 3'd5; m1_a_size = 4'd2; m1_a_source = 4'd0; m1_a_address = 2'd2;
        m1_a_mask = 4'h3; m1_a_data = M1_DATA; m1_a_corrupt = 1'b1; m1_a_valid = 1'b0; m1_d_ready = 1'b0;
        s_a_ready = 1'b0; s_d_opcode = 3'd1; s_d_param = 2'd0; s_d_size = 4'd2; s_d_source = 5'd0;
        s_d_denied = 1'b1; s_d_corrupt = 1'b0; s_d_data = SD_DATA; s_d_valid = 1'b0;

        // reset gating, then lone Get and its response
        vq.push_back(mk(1, 1,GET,2,3, 1,PF,2,2, 1, 1,5'h03,1,1, 0,5'h00,0,0, 0,0,0));
        vq.push_back(mk(1, 0,GET,2,3, 0,PF,2,2, 1, 0,5'h00,0,0, 0,5'h00,0,0, 0,0,0));
        vq.push_back(mk(0, 1,GET,2,3, 0,PF,2,2, 1, 0,5'h03,0,0, 1,5'h03,1,0, 0,0,0));
        vq.push_back(mk(0, 0,GET,2,3, 0,PF,2,2, 1, 1,5'h03,1,0, 0,5'h00,1,0, 1,0,1));
        // strict alternation after reset
        vq.push_back(mk(1, 0,PF,2,1, 0,PF,2,2, 1, 0,5'h00,0,0, 0,5'h00,0,0, 0,0,0));
        vq.push_back(mk(0, 1,PF,2,1, 1,PF,2,2, 1, 0,5'h00,0,0, 1,5'h01,1,0, 0,0,0));
        vq.push_back(mk(0, 1,PF,2,1, 1,PF,2,2, 1, 0,5'h00,0,0, 1,5'h12,0,1, 0,0,0));
        vq.push_back(mk(0, 1,PF,2,1, 1,PF,2,2, 1, 0,5'h00,0,0, 1,5'h01,1,0, 0,0,0));
        vq.push_back(mk(0, 1,PF,2,1, 1,PF,2,2, 1, 0,5'h00,0,0, 1,5'h12,0,1, 0,0,0));
        // m0 alone moves prio to m1, then m1's 4-beat message locks out m0
        vq.push_back(mk(0, 1,PF,2,1, 0,PF,2,2, 1, 0,5'h00,0,0, 1,5'h01,1,0, 0,0,0));
        for (int i = 0; i < 4; i++)
            vq.push_back(mk(0, 1,PF,2,1, 1,PF,4,5, 1, 0,5'h00,0,0, 1,5'h15,0,1, 0,0,0));
        vq.push_back(mk(0, 1,PF,2,1, 1,PF,4,5, 1, 0,5'h00,0,0, 1,5'h01,1,0, 0,0,0));
        // stalled Get held on m0 although m1 has priority
        vq.push_back(mk(0, 1,GET,2,3, 0,PF,2,2, 0, 0,5'h00,0,0, 1,5'h03,0,0, 0,0,0));
        vq.push_back(mk(0, 1,GET,2,3, 1,PF,2,2, 0, 0,5'h00,0,0, 1,5'h03,0,0, 0,0,0));
        vq.push_back(mk(0, 1,GET,2,3, 1,PF,2,2, 0, 0,5'h00,0,0, 1,5'h03,0,0, 0,0,0));
        vq.push_back(mk(0, 1,GET,2,3, 1,PF,2,2, 1, 0,5'h00,0,0, 1,5'h03,1,0, 0,0,0));
        vq.push_back(mk(0, 1,GET,2,3, 1,PF,2,2, 1, 0,5'h00,0,0, 1,5'h12,0,1, 0,0,0));
        // D to m1 with backpressure while m0 A beats fire
        vq.push_back(mk(0, 1,PF,2,1, 0,PF,2,2, 1, 1,5'h15,1,0, 1,5'h01,1,0, 0,1,0));
        vq.push_back(mk(0, 1,PF,2,1, 0,PF,2,2, 1, 1,5'h15,1,0, 1,5'h01,1,0, 0,1,0));
        vq.push_back(mk(0, 1,PF,2,1, 0,PF,2,2, 1, 1,5'h15,0,1, 1,5'h01,1,0, 0,1,1));
        // reset after beat 2 of an 8-beat LogicalData
        vq.push_back(mk(0, 1,LG,5,7, 0,PF,2,2, 1, 0,5'h00,0,0, 1,5'h07,1,0, 0,0,0));
        vq.push_back(mk(0, 1,LG,5,7, 1,PF,2,2, 1, 0,5'h00,0,0, 1,5'h07,1,0, 0,0,0));
        vq.push_back(mk(1, 1,LG,5,7, 1,PF,2,2, 1, 1,5'h15,1,1, 0,5'h00,0,0, 0,0,0));
        vq.push_back(mk(0, 1,PF,2,1, 1,PF,2,2, 1, 0,5'h00,0,0, 1,5'h01,1,0, 0,0,0));
        vq.push_back(mk(0, 0,PF,2,1, 1,PF,2,2, 1, 0,5'h00,0,0, 1,5'h12,0,1, 0,0,0));
        // valid dropped mid-burst keeps the lock; size 13 is a single beat
        vq.push_back(mk(0, 1,LG,3,1, 1,PF,13,2, 1, 0,5'h00,0,0, 1,5'h01,1,0, 0,0,0));
        vq.push_back(mk(0, 0,LG,3,1, 1,PF,13,2, 1, 0,5'h00,0,0, 0,5'h00,1,0, 0,0,0));
        vq.push_back(mk(0, 1,LG,3,1, 1,PF,13,2, 1, 0,5'h00,0,0, 1,5'h01,1,0, 0,0,0));
        vq.push_back(mk(0, 1,LG,3,1, 1,PF,13,2, 1, 0,5'h00,0,0, 1,5'h12,0,1, 0,0,0));
        vq.push_back(mk(0, 1,LG,3,1, 1,PF,13,2, 1, 0,5'h00,0,0, 1,5'h01,1,0, 0,0,0));
        vq.push_back(mk(0, 1,LG,3,1, 1,PF,13,2, 1, 0,5'h00,0,0, 1,5'h01,1,0, 0,0,0));

        @(posedge clk); #1;
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            @(negedge clk);
            check_row(vq[i], i);
            @(posedge clk); #1;
        end

        // 4 KiB PutFull from m0: 1024 beats with m1 waiting from the second beat on
        s_d_valid = 1'b0; s_a_ready = 1'b1;
        m0_a_valid = 1'b1; m0_a_opcode = PF; m0_a_size = 4'd12; m0_a_source = 4'd1;
        m1_a_valid = 1'b0; m1_a_opcode = PF; m1_a_size = 4'd2; m1_a_source = 4'd2;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (i == 0 || i == 1023 || m0_a_ready !== 1'b1 || m1_a_ready !== 1'b0) begin
                chk("burst_m0_ready", 1000 + i, 64'(m0_a_ready), 64'd1);
                chk("burst_m1_ready", 1000 + i, 64'(m1_a_ready), 64'd0);
            end
            @(posedge clk); #1;
            m1_a_valid = 1'b1;
        end
        @(negedge clk);
        chk("post_burst_m1_ready", 2024, 64'(m1_a_ready), 64'd1);
        chk("post_burst_m0_ready", 2024, 64'(m0_a_ready), 64'd0);
        chk("post_burst_source", 2024, 64'(s_a_source), 64'h12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
